// File: rtl/wbudecompress.sv
// Expands 36-bit bus codewords into resolved Wishbone commands (set-address, write,
// read, end-of-write). Relative addresses and compressed writes are resolved in-line.
module wbudecompress #(
    parameter int LGTBL = 9
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_stb,
    input  logic [35:0] i_codword,
    output logic        o_stb,
    output logic [1:0]  o_cmd,
    output logic        o_inc,
    output logic [31:0] o_data,
    output logic        o_err
);

    localparam int TBLSZ = 1 << LGTBL;

    typedef enum logic [1:0] {
        CMD_SETADDR = 2'b00,
        CMD_WRITE   = 2'b01,
        CMD_READ    = 2'b10,
        CMD_EOW     = 2'b11
    } cmd_e;

    // Tracked address and history-table bookkeeping
    logic [31:0]      addr_q, addr_d;
    logic [LGTBL-1:0] wptr_q, wptr_d;
    logic [LGTBL:0]   fill_q, fill_d;

    // Stage 1: decoded command, waiting on the table read
    logic             s1_valid_q, s1_valid_d;
    logic             s1_err_q, s1_err_d;
    logic             s1_fromram_q, s1_fromram_d;
    cmd_e             s1_cmd_q, s1_cmd_d;
    logic             s1_inc_q, s1_inc_d;
    logic [31:0]      s1_data_q, s1_data_d;

    // Stage 2: output registers
    logic             out_stb_q, out_stb_d;
    logic             out_err_q, out_err_d;
    cmd_e             out_cmd_q, out_cmd_d;
    logic             out_inc_q, out_inc_d;
    logic [31:0]      out_data_q, out_data_d;

    logic [31:0]      tbl [TBLSZ];
    logic [31:0]      ram_rdata_q;
    logic             tbl_we;
    logic [31:0]      tbl_wdata;
    logic [LGTBL-1:0] tbl_raddr;

    logic [31:0]      rel_off;
    logic [31:0]      rel_addr;
    logic [LGTBL-1:0] idx_ext;
    logic [LGTBL:0]   fill_full;

    always_comb begin
        case (i_codword[32:31])
            2'b00:   rel_off = {{26{i_codword[29]}}, i_codword[29:24]};
            2'b01:   rel_off = {{20{i_codword[29]}}, i_codword[29:18]};
            2'b10:   rel_off = {{14{i_codword[29]}}, i_codword[29:12]};
            default: rel_off = {{8{i_codword[29]}}, i_codword[29:6]};
        endcase
    end

    assign rel_addr  = addr_q + rel_off;
    assign idx_ext   = LGTBL'(i_codword[32:24]);
    assign tbl_raddr = wptr_q - idx_ext - LGTBL'(1);
    assign fill_full = {1'b1, {LGTBL{1'b0}}};

    always_comb begin
        addr_d       = addr_q;
        wptr_d       = wptr_q;
        fill_d       = fill_q;
        s1_valid_d   = 1'b0;
        s1_err_d     = 1'b0;
        s1_fromram_d = 1'b0;
        s1_cmd_d     = CMD_SETADDR;
        s1_inc_d     = 1'b0;
        s1_data_d    = '0;
        tbl_we       = 1'b0;
        tbl_wdata    = i_codword[31:0];

        if (i_stb) begin
            s1_valid_d = 1'b1;
            if (!i_codword[35]) begin
                case (i_codword[34:33])
                    2'b00: begin
                        addr_d    = i_codword[31:0];
                        s1_inc_d  = i_codword[32];
                        s1_data_d = i_codword[31:0];
                    end
                    2'b01: begin
                        addr_d    = rel_addr;
                        s1_inc_d  = i_codword[30];
                        s1_data_d = rel_addr;
                    end
                    2'b10: begin
                        // Reference older than anything stored is dropped and flagged
                        s1_cmd_d = CMD_WRITE;
                        if ({1'b0, idx_ext} >= fill_q)
                            s1_err_d = 1'b1;
                        else
                            s1_fromram_d = 1'b1;
                    end
                    default: begin
                        s1_cmd_d  = CMD_WRITE;
                        s1_data_d = i_codword[31:0];
                        tbl_we    = 1'b1;
                        wptr_d    = wptr_q + LGTBL'(1);
                        if (fill_q != fill_full)
                            fill_d = fill_q + 1'b1;
                    end
                endcase
            end else if (!i_codword[34]) begin
                if (i_codword[33:30] == 4'hE) begin
                    s1_cmd_d  = CMD_EOW;
                    s1_data_d = '0;
                end else begin
                    s1_cmd_d  = CMD_READ;
                    s1_data_d = 32'(i_codword[33:30]) + 32'd1;
                end
            end else begin
                s1_cmd_d  = CMD_READ;
                s1_data_d = 32'(i_codword[33:24]) + 32'd1;
            end
        end
    end

    always_comb begin
        out_stb_d  = s1_valid_q & ~s1_err_q;
        out_err_d  = s1_valid_q & s1_err_q;
        out_cmd_d  = out_cmd_q;
        out_inc_d  = out_inc_q;
        out_data_d = out_data_q;
        if (s1_valid_q && !s1_err_q) begin
            out_cmd_d  = s1_cmd_q;
            out_inc_d  = s1_inc_q;
            out_data_d = s1_fromram_q ? ram_rdata_q : s1_data_q;
        end
    end

    // A long write lands on the same edge its successor's table read is issued
    // one cycle later, so an idx=0 reference always sees the fresh entry.
    always_ff @(posedge i_clk) begin
        if (tbl_we)
            tbl[wptr_q] <= tbl_wdata;
        ram_rdata_q <= tbl[tbl_raddr];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            addr_q       <= '0;
            wptr_q       <= '0;
            fill_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_fromram_q <= 1'b0;
            s1_cmd_q     <= CMD_SETADDR;
            s1_inc_q     <= 1'b0;
            s1_data_q    <= '0;
            out_stb_q    <= 1'b0;
            out_err_q    <= 1'b0;
            out_cmd_q    <= CMD_SETADDR;
            out_inc_q    <= 1'b0;
            out_data_q   <= '0;
        end else begin
            addr_q       <= addr_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            s1_valid_q   <= s1_valid_d;
            s1_err_q     <= s1_err_d;
            s1_fromram_q <= s1_fromram_d;
            s1_cmd_q     <= s1_cmd_d;
            s1_inc_q     <= s1_inc_d;
            s1_data_q    <= s1_data_d;
            out_stb_q    <= out_stb_d;
            out_err_q    <= out_err_d;
            out_cmd_q    <= out_cmd_d;
            out_inc_q    <= out_inc_d;
            out_data_q   <= out_data_d;
        end
    end

    assign o_stb  = out_stb_q;
    assign o_err  = out_err_q;
    assign o_cmd  = out_cmd_q;
    assign o_inc  = out_inc_q;
    assign o_data = out_data_q;

endmodule

// File: tb/tb_wbudecompress.sv
// Bench for wbudecompress: directed literal cases plus a randomized mixed stream
// compared every cycle against a queue-based reference model.
module tb_wbudecompress;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_stb = 1'b0;
    logic [35:0] i_codword = '0;
    logic        o_stb;
    logic [1:0]  o_cmd;
    logic        o_inc;
    logic [31:0] o_data;
    logic        o_err;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    wbudecompress #(.LGTBL(9)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_stb     (i_stb),
        .i_codword (i_codword),
        .o_stb     (o_stb),
        .o_cmd     (o_cmd),
        .o_inc     (o_inc),
        .o_data    (o_data),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit        stb;
        bit        err;
        bit [1:0]  cmd;
        bit        inc;
        bit [31:0] data;
    } res_t;

    // Reference model state: tracked address, history newest-first, pending and visible outputs
    bit [31:0] m_addr;
    bit [31:0] m_hist[$];
    res_t      pend;
    res_t      expo;

    function automatic res_t modelStep(bit stb, bit [35:0] cw);
        res_t    r;
        int      w;
        int      idx;
        bit [23:0] field;
        longint  off;
        r = '{default: 0};
        if (!stb) return r;
        if (cw[35:34] == 2'b10) begin
            r.stb = 1;
            if (cw[33:30] == 4'hE) begin
                r.cmd = 2'b11;
                r.data = 0;
            end else begin
                r.cmd = 2'b10;
                r.data = 32'(cw[33:30]) + 1;
            end
        end else if (cw[35:34] == 2'b11) begin
            r.stb = 1;
            r.cmd = 2'b10;
            r.data = 32'(cw[33:24]) + 1;
        end else begin
            case (cw[35:33])
                3'b000: begin
                    m_addr = cw[31:0];
                    r.stb = 1; r.cmd = 2'b00; r.inc = cw[32]; r.data = m_addr;
                end
                3'b001: begin
                    w = 6 * (int'(cw[32:31]) + 1);
                    field = cw[29:6] >> (24 - w);
                    off = longint'(field);
                    if (off >= (64'sd1 <<< (w - 1))) off = off - (64'sd1 <<< w);
                    m_addr = m_addr + 32'(off);
                    r.stb = 1; r.cmd = 2'b00; r.inc = cw[30]; r.data = m_addr;
                end
                3'b010: begin
                    idx = int'(cw[32:24]);
                    if (idx >= m_hist.size()) begin
                        r.err = 1;
                    end else begin
                        r.stb = 1; r.cmd = 2'b01; r.data = m_hist[idx];
                    end
                end
                default: begin
                    m_hist.push_front(cw[31:0]);
                    if (m_hist.size() > 512) void'(m_hist.pop_back());
                    r.stb = 1; r.cmd = 2'b01; r.data = cw[31:0];
                end
            endcase
        end
        return r;
    endfunction

    initial begin
        m_addr = 0;
        pend = '{default: 0};
        expo = '{default: 0};
        forever begin
            @(posedge i_clk or negedge i_reset_n);
            if (!i_reset_n) begin
                m_addr = 0;
                m_hist.delete();
                pend = '{default: 0};
                expo = '{default: 0};
            end else begin
                if (pend.stb) begin
                    expo.stb = 1; expo.err = 0;
                    expo.cmd = pend.cmd; expo.inc = pend.inc; expo.data = pend.data;
                end else begin
                    expo.stb = 0; expo.err = pend.err;
                end
                pend = modelStep(i_stb, i_codword);
            end
        end
    end

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge i_clk);
            if (cmp_en) begin
                checkField("model_stb", 32'(o_stb), 32'(expo.stb));
                checkField("model_err", 32'(o_err), 32'(expo.err));
                checkField("model_cmd", 32'(o_cmd), 32'(expo.cmd));
                checkField("model_data", o_data, expo.data);
                if (expo.cmd == 2'b00)
                    checkField("model_inc", 32'(o_inc), 32'(expo.inc));
            end
        end
    end

    task automatic checkOutput(input string name, input bit stb, input bit err,
                               input bit [1:0] cmd, input bit inc, input bit [31:0] data);
        checkField({name, "_stb"}, 32'(o_stb), 32'(stb));
        checkField({name, "_err"}, 32'(o_err), 32'(err));
        checkField({name, "_cmd"}, 32'(o_cmd), 32'(cmd));
        checkField({name, "_data"}, o_data, data);
        if (cmd == 2'b00)
            checkField({name, "_inc"}, 32'(o_inc), 32'(inc));
    endtask

    task automatic applyStimulus(input bit [35:0] cw, input bit stb);
        @(posedge i_clk);
        #1;
        i_stb = stb;
        i_codword = cw;
    endtask

    task automatic sendOne(input bit [35:0] cw);
        applyStimulus(cw, 1'b1);
        applyStimulus(36'h0, 1'b0);
        @(negedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic doReset();
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        i_stb = 1'b0;
        repeat (2) @(negedge i_clk);
        #2 i_reset_n = 1'b1;
    endtask

    function automatic bit [35:0] randCw();
        bit [63:0] r;
        bit [35:0] cw;
        int sel;
        r = {$urandom(), $urandom()};
        cw = r[35:0];
        sel = $urandom_range(0, 99);
        if (sel < 10)       cw[35:33] = 3'b000;
        else if (sel < 25)  cw[35:33] = 3'b001;
        else if (sel < 45) begin
            cw[35:33] = 3'b010;
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: cw[32:24] = 9'($urandom_range(0, 15));
                default:       cw[32:24] = 9'($urandom_range(0, 511));
            endcase
        end
        else if (sel < 75)  cw[35:33] = 3'b011;
        else if (sel < 87)  cw[35:34] = 2'b10;
        else                cw[35:34] = 2'b11;
        return cw;
    endfunction

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] start");
        repeat (2) @(negedge i_clk);
        cmp_en = 1'b1;
        checkOutput("reset_state", 0, 0, 2'b00, 0, 32'h0);
        #2 i_reset_n = 1'b1;

        sendOne(36'h0_1234_5678);
        checkOutput("set_abs", 1, 0, 2'b00, 0, 32'h1234_5678);
        sendOne(36'h2_3F00_0000);
        checkOutput("set_rel_minus1", 1, 0, 2'b00, 0, 32'h1234_5677);
        sendOne(36'h1_0000_0100);
        checkOutput("set_abs_inc", 1, 0, 2'b00, 1, 32'h0000_0100);
        sendOne(36'h0_FFFF_FFFF);
        checkOutput("set_abs_max", 1, 0, 2'b00, 0, 32'hFFFF_FFFF);
        sendOne(36'h2_0100_0000);
        checkOutput("set_rel_wrap", 1, 0, 2'b00, 0, 32'h0000_0000);

        sendOne(36'h6_0000_000A);
        checkOutput("long_wr_a", 1, 0, 2'b01, 0, 32'hA);
        sendOne(36'h6_0000_000B);
        sendOne(36'h6_0000_000C);
        sendOne(36'h4_0000_0000);
        checkOutput("cmp_idx0", 1, 0, 2'b01, 0, 32'hC);
        sendOne(36'h4_0200_0000);
        checkOutput("cmp_idx2", 1, 0, 2'b01, 0, 32'hA);

        applyStimulus(36'h6_DEAD_BEEF, 1'b1);
        applyStimulus(36'h4_0000_0000, 1'b1);
        applyStimulus(36'h0, 1'b0);
        @(negedge i_clk);
        checkOutput("bypass_long", 1, 0, 2'b01, 0, 32'hDEAD_BEEF);
        @(negedge i_clk);
        checkOutput("bypass_cmp", 1, 0, 2'b01, 0, 32'hDEAD_BEEF);

        sendOne(36'h8_C000_0000);
        checkOutput("short_read", 1, 0, 2'b10, 0, 32'd4);
        sendOne(36'hB_8000_0000);
        checkOutput("end_of_write", 1, 0, 2'b11, 0, 32'd0);
        sendOne(36'hF_FF00_0000);
        checkOutput("long_read_max", 1, 0, 2'b10, 0, 32'd1024);

        doReset();
        sendOne(36'h4_0000_0000);
        checkOutput("err_empty", 0, 1, 2'b00, 0, 32'h0);
        @(negedge i_clk);
        checkOutput("err_pulse_end", 0, 0, 2'b00, 0, 32'h0);
        sendOne(36'h2_0100_0000);
        checkOutput("err_addr_kept", 1, 0, 2'b00, 0, 32'h1);
        sendOne(36'h4_0000_0000);
        checkOutput("err_fill_kept", 0, 1, 2'b00, 0, 32'h1);

        for (int i = 0; i < 1000; i++)
            applyStimulus(randCw(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(randCw(), 1'b1);
        @(negedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        checkOutput("midreset_now", 0, 0, 2'b00, 0, 32'h0);
        for (int i = 0; i < 2; i++)
            applyStimulus(randCw(), 1'b1);
        applyStimulus(36'h0, 1'b0);
        @(negedge i_clk);
        #2 i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            checkOutput("post_reset_idle", 0, 0, 2'b00, 0, 32'h0);
        end

        for (int i = 0; i < 3000; i++)
            applyStimulus(randCw(), $urandom_range(0, 4) != 0);
        applyStimulus(36'h0, 1'b0);
        repeat (4) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
